// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of the 4-slot TDM link. The slot counter is aligned
// by sync. Slots 0..2 are held in shadow registers. All four channels are
// published together when slot 3 arrives.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sync,
  output logic [4*WIDTH-1:0] dout,
  output logic               frame_valid,
  output logic               sync_err,
  output logic               locked,
  output logic [1:0]         slot
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  logic [2:0][WIDTH-1:0]   shadow_q, shadow_d;
  logic [4*WIDTH-1:0]      dout_q, dout_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;

  // Register update. Reset wins over everything, so any partial frame is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= 2'd0;
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  // Framing FSM. Unqualified beats hold all state and only drop the pulses.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d[0] = din;
            slot_d      = 2'd1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // A sync that arrives mid-frame restarts the frame on this beat.
            if (slot_q != 2'd0) begin
              err_d       = 1'b1;
              shadow_d[1] = '0;
              shadow_d[2] = '0;
            end
            shadow_d[0] = din;
            slot_d      = 2'd1;
          end else begin
            case (slot_q)
              2'd0: begin
                // A missing sync means alignment is lost. Drop the beat and re-hunt.
                err_d   = 1'b1;
                state_d = HUNT;
              end
              2'd1: begin
                shadow_d[1] = din;
                slot_d      = 2'd2;
              end
              2'd2: begin
                shadow_d[2] = din;
                slot_d      = 2'd3;
              end
              default: begin
                // Slot 3 is taken straight from din so the frame lands on this edge.
                dout_d = {din, shadow_q};
                fv_d   = 1'b1;
                slot_d = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == RUN);
  assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed vector table, a hand-written back-to-back sequence,
// and random traffic checked against a queue-based frame model.
module tb_tdm_demux4;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst, din_valid, sync;
  logic [W-1:0]  din;
  logic [4*W-1:0] dout;
  logic          frame_valid, sync_err, locked;
  logic [1:0]    slot;

  int tests = 0;
  int fails = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .dout(dout), .frame_valid(frame_valid), .sync_err(sync_err),
    .locked(locked), .slot(slot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           r, v, s;
    logic [W-1:0]   d;
    logic [4*W-1:0] edout;
    logic           efv, eerr, elk;
    logic [1:0]     eslot;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, v, s, input logic [W-1:0] d,
                              input logic [4*W-1:0] edout,
                              input logic efv, eerr, elk, input logic [1:0] eslot);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d;
    t.edout = edout; t.efv = efv; t.eerr = eerr; t.elk = elk; t.eslot = eslot;
    vecs.push_back(t);
  endfunction

  // Drive one beat, take the edge, then sample 1 time unit later.
  task automatic step(input logic r, v, s, input logic [W-1:0] d);
    rst = r; din_valid = v; sync = s; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4*W-1:0] edout,
                     input logic efv, eerr, elk, input logic [1:0] eslot);
    tests++;
    if (dout !== edout || frame_valid !== efv || sync_err !== eerr ||
        locked !== elk || slot !== eslot) begin
      fails++;
      $display("FAIL %s: got dout=%h fv=%b err=%b lk=%b slot=%0d, want dout=%h fv=%b err=%b lk=%b slot=%0d",
               name, dout, frame_valid, sync_err, locked, slot,
               edout, efv, eerr, elk, eslot);
    end
  endtask

  // The model tracks the frame being collected as a queue of words. Its
  // length is the slot index.
  logic [W-1:0]   mq[$];
  logic           mlk, mfv, merr;
  logic [4*W-1:0] mdout;

  task automatic model_step(input logic r, v, s, input logic [W-1:0] d);
    mfv = 1'b0; merr = 1'b0;
    if (r) begin
      mq.delete(); mlk = 1'b0; mdout = '0;
    end else if (v) begin
      if (!mlk) begin
        if (s) begin mq.delete(); mq.push_back(d); mlk = 1'b1; end
      end else if (s) begin
        if (mq.size() != 0) merr = 1'b1;
        mq.delete(); mq.push_back(d);
      end else if (mq.size() == 0) begin
        merr = 1'b1; mlk = 1'b0;
      end else begin
        mq.push_back(d);
        if (mq.size() == 4) begin
          mdout = {mq[3], mq[2], mq[1], mq[0]};
          mfv = 1'b1;
          mq.delete();
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = '0;

    // 1: basic frame
    add(1,0,0,4'h0, 16'h0000,0,0,0,0);
    add(0,1,1,4'h1, 16'h0000,0,0,1,1);
    add(0,1,0,4'h2, 16'h0000,0,0,1,2);
    add(0,1,0,4'h3, 16'h0000,0,0,1,3);
    add(0,1,0,4'h4, 16'h4321,1,0,1,0);
    // 2: same frame with gaps
    add(0,0,0,4'h7, 16'h4321,0,0,1,0);
    add(0,1,1,4'h1, 16'h4321,0,0,1,1);
    add(0,0,1,4'h8, 16'h4321,0,0,1,1);
    add(0,1,0,4'h2, 16'h4321,0,0,1,2);
    add(0,0,0,4'h9, 16'h4321,0,0,1,2);
    add(0,0,1,4'h9, 16'h4321,0,0,1,2);
    add(0,1,0,4'h3, 16'h4321,0,0,1,3);
    add(0,0,0,4'h5, 16'h4321,0,0,1,3);
    add(0,1,0,4'h4, 16'h4321,1,0,1,0);
    // 3: hunt ignores unsynced beats
    add(1,0,0,4'h0, 16'h0000,0,0,0,0);
    add(0,1,0,4'h9, 16'h0000,0,0,0,0);
    add(0,1,0,4'h9, 16'h0000,0,0,0,0);
    add(0,1,0,4'h9, 16'h0000,0,0,0,0);
    add(0,1,1,4'hA, 16'h0000,0,0,1,1);
    add(0,1,0,4'hB, 16'h0000,0,0,1,2);
    add(0,1,0,4'hC, 16'h0000,0,0,1,3);
    add(0,1,0,4'hD, 16'hDCBA,1,0,1,0);
    // 4: early sync
    add(0,1,1,4'h5, 16'hDCBA,0,0,1,1);
    add(0,1,0,4'h6, 16'hDCBA,0,0,1,2);
    add(0,1,1,4'h7, 16'hDCBA,0,1,1,1);
    add(0,1,0,4'h8, 16'hDCBA,0,0,1,2);
    add(0,1,0,4'h9, 16'hDCBA,0,0,1,3);
    add(0,1,0,4'hA, 16'hA987,1,0,1,0);
    // 5: missing sync
    add(0,1,0,4'h1, 16'hA987,0,1,0,0);
    add(0,0,0,4'h0, 16'hA987,0,0,0,0);
    add(0,1,1,4'h1, 16'hA987,0,0,1,1);
    add(0,1,0,4'h1, 16'hA987,0,0,1,2);
    add(0,1,0,4'h1, 16'hA987,0,0,1,3);
    add(0,1,0,4'h1, 16'h1111,1,0,1,0);
    // 6: reset mid-frame, including rst with a qualified beat
    add(0,1,1,4'h2, 16'h1111,0,0,1,1);
    add(0,1,0,4'h3, 16'h1111,0,0,1,2);
    add(1,1,0,4'h5, 16'h0000,0,0,0,0);
    add(1,1,1,4'h6, 16'h0000,0,0,0,0);
    add(0,1,1,4'hE, 16'h0000,0,0,1,1);
    add(0,1,0,4'hF, 16'h0000,0,0,1,2);
    add(0,1,0,4'h0, 16'h0000,0,0,1,3);
    add(0,1,0,4'h1, 16'h10FE,1,0,1,0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].d);
      chk($sformatf("vec%0d", i), vecs[i].edout, vecs[i].efv, vecs[i].eerr,
          vecs[i].elk, vecs[i].eslot);
    end

    // Back-to-back frames: frame_valid on every 4th cycle
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        logic [W-1:0] dv;
        dv = W'(f * 4 + k);
        step(1'b0, 1'b1, (k == 0), dv);
        if (k == 3)
          chk($sformatf("b2b_f%0d", f),
              {W'(f*4+3), W'(f*4+2), W'(f*4+1), W'(f*4)}, 1'b1, 1'b0, 1'b1, 2'd0);
        else
          chk($sformatf("b2b_f%0d_k%0d", f, k),
              (f == 0) ? 16'h10FE : {W'(f*4-1), W'(f*4-2), W'(f*4-3), W'(f*4-4)},
              1'b0, 1'b0, 1'b1, 2'(k + 1));
      end
    end

    // Random traffic against the model
    step(1'b1, 1'b0, 1'b0, '0);
    model_step(1'b1, 1'b0, 1'b0, '0);
    chk("rand_reset", mdout, mfv, merr, mlk, 2'(mq.size()));
    for (int n = 0; n < 3000; n++) begin
      logic r, v, s;
      logic [W-1:0] d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (!mlk || mq.size() == 0) s = ($urandom_range(0, 9) != 0);
      else                        s = ($urandom_range(0, 19) == 0);
      d = W'($urandom);
      model_step(r, v, s, d);
      step(r, v, s, d);
      chk($sformatf("rand%0d", n), mdout, mfv, merr, mlk, 2'(mq.size()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
